// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and the visible window bounds
// shared with the rgb/game block for sprite clipping.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int CLK_DIV = 4;

  localparam int H_TOTAL      = 800;
  localparam int H_SYNC       = 96;
  localparam int H_DISP_START = 144;
  localparam int H_DISP_END   = 783;

  localparam int V_TOTAL      = 525;
  localparam int V_SYNC       = 2;
  localparam int V_DISP_START = 35;
  localparam int V_DISP_END   = 514;

  localparam int VIS_X0 = H_DISP_START;
  localparam int VIS_X1 = H_DISP_END;
  localparam int VIS_Y0 = V_DISP_START;
  localparam int VIS_Y1 = V_DISP_END;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_clk_en_div.sv
// Modulo-DIV free-running counter; en is high in the last count
// of each period and serves as the pixel strobe.
module clk_en_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic en
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign en = (cnt_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters with registered sync, bright and frame_tick
// decoded from the next counter values.
module vga_timing_gen #(
  parameter int CLK_DIV      = vga_timing_pkg::CLK_DIV,
  parameter int H_TOTAL      = vga_timing_pkg::H_TOTAL,
  parameter int H_SYNC       = vga_timing_pkg::H_SYNC,
  parameter int H_DISP_START = vga_timing_pkg::H_DISP_START,
  parameter int H_DISP_END   = vga_timing_pkg::H_DISP_END,
  parameter int V_TOTAL      = vga_timing_pkg::V_TOTAL,
  parameter int V_SYNC       = vga_timing_pkg::V_SYNC,
  parameter int V_DISP_START = vga_timing_pkg::V_DISP_START,
  parameter int V_DISP_END   = vga_timing_pkg::V_DISP_END
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_tick
);

  import vga_timing_pkg::coord_t;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t H_SW   = coord_t'(H_SYNC);
  localparam coord_t V_SW   = coord_t'(V_SYNC);
  localparam coord_t H_B0   = coord_t'(H_DISP_START);
  localparam coord_t H_B1   = coord_t'(H_DISP_END);
  localparam coord_t V_B0   = coord_t'(V_DISP_START);
  localparam coord_t V_B1   = coord_t'(V_DISP_END);
  localparam coord_t V_TICK = coord_t'(V_DISP_END + 1);

  coord_t h_q, h_d;
  coord_t v_q, v_d;
  logic   hs_q, hs_d;
  logic   vs_q, vs_d;
  logic   br_q, br_d;
  logic   ft_q, ft_d;
  logic   pix_en_w;

  clk_en_div #(.DIV(CLK_DIV)) u_div (
    .clk (clk),
    .rst (rst),
    .en  (pix_en_w)
  );

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en_w) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // h_d can only be 0 under pix_en via a line wrap, so the tick
  // fires once on entry to the blanking start, not while held there.
  always_comb begin
    hs_d = (h_d >= H_SW);
    vs_d = (v_d >= V_SW);
    br_d = (h_d >= H_B0) && (h_d <= H_B1) &&
           (v_d >= V_B0) && (v_d <= V_B1);
    ft_d = pix_en_w && (h_d == '0) && (v_d == V_TICK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q  <= '0;
      v_q  <= '0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      br_q <= 1'b0;
      ft_q <= 1'b0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      br_q <= br_d;
      ft_q <= ft_d;
    end
  end

  assign pix_en     = pix_en_w;
  assign hCount     = h_q;
  assign vCount     = v_q;
  assign hSync      = hs_q;
  assign vSync      = vs_q;
  assign bright     = br_q;
  assign frame_tick = ft_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 100 MHz board clock.
- Drives hCount, vCount and bright into the game/rgb block.
- Drives hSync and vSync to the connector.
- Emits a once-per-frame frame_tick so game logic can advance object positions during vertical blanking.

Parameters:
- CLK_DIV, 4: board clocks per pixel (100 MHz -> 25 MHz pixel rate).
- H_TOTAL, 800: pixels per line.
- H_SYNC, 96: hSync low width in pixels.
- H_DISP_START, 144: first visible hCount.
- H_DISP_END, 783: last visible hCount.
- V_TOTAL, 525: lines per frame.
- V_SYNC, 2: vSync low width in lines.
- V_DISP_START, 35: first visible vCount.
- V_DISP_END, 514: last visible vCount.

Ports:
- clk, input, 1: board clock. All logic is on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
- pix_en, output, 1: one-clk pulse, once every CLK_DIV clocks; the pixel strobe.
- hCount, output, 10: horizontal pixel counter, 0..H_TOTAL-1.
- vCount, output, 10: vertical line counter, 0..V_TOTAL-1.
- hSync, output, 1: horizontal sync, active low.
- vSync, output, 1: vertical sync, active low.
- bright, output, 1: high while (hCount,vCount) is inside the visible window.
- frame_tick, output, 1: one-clk pulse at the start of vertical blanking.

Behaviour:
- Single clock domain. Reset is synchronous, active-high, on port rst, clocked by clk. No async paths.
- Reset values, in force the cycle after rst is sampled high:
  - div_cnt=0, hCount=0, vCount=0.
  - pix_en=0, bright=0, frame_tick=0.
  - hSync=0 and vSync=0: counters at 0 lie inside the sync pulses.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en=1 exactly in the cycles where div_cnt==CLK_DIV-1.
  - First pix_en occurs CLK_DIV clocks after rst deasserts.
- Counter advance happens only on a clk edge where pix_en=1:
  - hCount < H_TOTAL-1: hCount+1.
  - hCount == H_TOTAL-1: hCount=0, and vCount advances (vCount+1, or 0 when vCount == V_TOTAL-1).
  - Counters hold value for CLK_DIV clocks between advances.
  - Counters never exceed the TOTAL-1 values. There is no other wrap path.
- Sync/bright decode:
  - Registered, updated on the same edge as the counters, computed from the next counter values. They are always cycle-aligned with the hCount/vCount outputs; no combinational glitches.
  - hSync = 0 iff hCount < H_SYNC.
  - vSync = 0 iff vCount < V_SYNC.
  - bright = 1 iff H_DISP_START <= hCount <= H_DISP_END and V_DISP_START <= vCount <= V_DISP_END, all bounds inclusive.
- frame_tick:
  - High for exactly one clk: the first clk in which (hCount,vCount) == (0, V_DISP_END+1).
  - Not re-asserted during the remaining CLK_DIV-1 clocks at that position.
  - Exactly one pulse per frame.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV = 1,680,000 clk.
- Reset mid-frame: all state returns to reset values on the next edge; no partial line/frame completes. No frame_tick pulse is emitted due to the reset.
- Simultaneous line and frame wrap at (799,524): both counters go to 0 on the same pix_en edge.

Decomposition:
- Package vga_timing_pkg holds:
  - the H_*/V_* constants;
  - the 10-bit coordinate width;
  - the visible-window bounds, also used by the rgb/game block for sprite clipping.
- One sub-module: clk_en_div, a parameterised modulo-CLK_DIV counter producing pix_en with synchronous reset.
- Counters and decode stay in vga_timing_gen.

Test Plan:
- Reset/pixel strobe: assert rst 3 clk, release -> in cycles 1..3 after release pix_en=0; first pix_en at clk 4, then every 4 clk; all outputs at reset values while rst=1.
- hSync width: release reset -> hSync=0 for 96*4=384 clk from hCount=0, rises when hCount becomes 96. Line wrap: hCount 799 -> 0 with vCount incrementing on the same edge.
- Visible window and vSync: run one full frame -> bright high on exactly 640*480=307,200 distinct pixel positions, first at (144,35), last at (783,514). vSync low exactly while vCount is 0..1 (2 lines = 6,400 clk).
- Frame wrap and tick: run 2 frames -> (799,524) -> (0,0) on one edge. frame_tick pulses once per frame, width 1 clk, at (0,515); pulses spaced 1,680,000 clk apart.
- Reset mid-frame: assert rst at (400,300) for 1 clk -> next cycle counters (0,0), hSync=0, vSync=0, bright=0. No frame_tick until (0,515) of the new frame.
